pmem_line_responder: RTL and testbench
======================================

Name: pmem_line_responder

Overview:
- Responder end of the 256-bit physical-memory line interface that cache_group drives as initiator (pmem_read/pmem_write/pmem_address/pmem_wdata -> pmem_rdata/pmem_resp).
- Holds a line-granular storage array and answers each line read or write after a fixed, parameterised latency with a single-cycle pmem_resp.
- Used as the synthesizable main-memory stand-in under mp3 for simulation and FPGA bring-up.

Parameters:
- INDEX_BITS, 8, log2 of line count; the array holds 2^INDEX_BITS lines of 256 bits.
- LATENCY, 4, cycles from request assertion to pmem_resp; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- pmem_read  input  1  line read request, held by initiator until resp
- pmem_write  input  1  line write request, held by initiator until resp
- pmem_address  input  32  byte address; bits [4:0] ignored, bits [INDEX_BITS+4:5] index the array, upper bits ignored (aliasing)
- pmem_wdata  input  256  write line data
- pmem_rdata  output  256  read line data, valid in the pmem_resp cycle
- pmem_resp  output  1  one-cycle completion pulse
- proto_err  output  1  sticky protocol-violation flag

Behaviour:
- Reset (async assert, sync release): state IDLE, pmem_resp=0, pmem_rdata=0, proto_err=0, counter=0. Array contents are not reset and are undefined until written.
- FSM states: IDLE, BUSY, RESP, RECOVER.
- IDLE:
  - On the edge sampling pmem_read|pmem_write high, latch op, index and wdata.
  - If LATENCY=1, go to RESP; else load counter=LATENCY-2 and go to BUSY.
- BUSY: at counter==0 go to RESP, else decrement.
- Timing: a request first high in cycle c gives pmem_resp=1 in cycle c+LATENCY, for exactly one cycle.
- Write: the array line is updated at the edge entering RESP.
- Read: pmem_rdata is registered at the edge entering RESP. It holds its value until the next read completes; writes do not change it.
- RESP -> RECOVER unconditionally. RECOVER ignores all requests for one cycle, covering the initiator dropping its request the cycle after resp, then goes to IDLE.
- Back-to-back: a request held high through RECOVER is accepted at the IDLE edge, so the minimum spacing between resp pulses is LATENCY+2 cycles.
- Address and wdata are latched at acceptance; changes during BUSY are ignored.
- Request dropped during BUSY (both read and write low): abort to IDLE, no resp, no array update, proto_err set.
- Read and write both high when sampled in IDLE: write takes priority, proto_err set.
- Read and write both high during BUSY: also sets proto_err; the latched op continues.
- Read-after-write to the same line on a later transaction returns the newly written data.
- Reset asserted mid-transaction: immediate return to IDLE, resp=0. An uncommitted write is lost; a write committed at an earlier RESP edge is retained.
- proto_err clears only on reset.

Test Plan:
- Write 0xA5 repeated (256 b) to 0x0000_0040 with LATENCY=4, request high from cycle 10 -> resp high only in cycle 14; then read 0x0000_0040 -> rdata equals 0xA5 pattern in its resp cycle, proto_err=0.
- Alias check, INDEX_BITS=8: write line X to 0x0000_2020, read 0x0000_0020 -> returns X; read of 0x0000_003F -> returns X (offset bits ignored).
- Back-to-back: read held continuously across two transactions -> resp pulses exactly LATENCY+2=6 cycles apart; RECOVER cycle does not start a transaction.
- Abort: assert read in cycle 0, drop it in cycle 2 -> no resp ever, FSM returns to IDLE, proto_err=1; a later write still completes normally.
- Simultaneous read+write to line 5 with wdata=W -> resp after LATENCY, array line 5 = W, pmem_rdata unchanged, proto_err=1.
- LATENCY=1 build: read high in cycle 3 -> resp in cycle 4. rst_n pulsed low during BUSY of a write -> resp stays 0, and a subsequent read of that line does not return the aborted data.

Source files
------------

// File: rtl/pmem_line_responder.sv
// Line-granular memory responder for the 256-bit pmem interface: answers each
// held read or write request with a one-cycle pmem_resp after LATENCY cycles.
module pmem_line_responder #(
    parameter int INDEX_BITS = 8,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [31:0]           pmem_address,
    input  logic [255:0]          pmem_wdata,
    output logic [255:0]          pmem_rdata,
    output logic                  pmem_resp,
    output logic                  proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESP    = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    localparam logic [7:0] CNT_INIT = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    is_write_q, is_write_d;
    logic [INDEX_BITS-1:0]   idx_q, idx_d;
    logic [255:0]            wdata_q, wdata_d;
    logic [255:0]            rdata_q, rdata_d;
    logic                    resp_q, resp_d;
    logic                    perr_q, perr_d;

    logic                    req_s;
    logic                    both_s;
    logic [INDEX_BITS-1:0]   addr_idx_s;
    logic                    mem_we_s;
    logic                    mem_wr_s;
    logic                    rd_en_s;
    logic [INDEX_BITS-1:0]   mem_idx_s;
    logic [255:0]            mem_wdata_s;
    logic                    unused_addr_s;

    logic [255:0]            mem_q [2**INDEX_BITS];

    assign req_s         = pmem_read | pmem_write;
    assign both_s        = pmem_read & pmem_write;
    assign addr_idx_s    = pmem_address[INDEX_BITS+4:5];
    assign unused_addr_s = ^{pmem_address[31:INDEX_BITS+5], pmem_address[4:0]};
    // A clock edge seen while reset is held must never commit a write.
    assign mem_wr_s      = mem_we_s & rst_n;

    // Next-state, latch and commit decisions for the request sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_write_d  = is_write_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        perr_d      = perr_q;
        resp_d      = 1'b0;
        mem_we_s    = 1'b0;
        rd_en_s     = 1'b0;
        mem_idx_s   = idx_q;
        mem_wdata_s = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    is_write_d = pmem_write;
                    idx_d      = addr_idx_s;
                    wdata_d    = pmem_wdata;
                    perr_d     = perr_q | both_s;
                    // With single-cycle latency the commit uses the live request.
                    if (LATENCY == 1) begin
                        state_d     = ST_RESP;
                        resp_d      = 1'b1;
                        mem_idx_s   = addr_idx_s;
                        mem_wdata_s = pmem_wdata;
                        mem_we_s    = pmem_write;
                        rd_en_s     = ~pmem_write;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!req_s) begin
                    state_d = ST_IDLE;
                    perr_d  = 1'b1;
                end else begin
                    perr_d = perr_q | both_s;
                    if (cnt_q == 8'd0) begin
                        state_d  = ST_RESP;
                        resp_d   = 1'b1;
                        mem_we_s = is_write_q;
                        rd_en_s  = ~is_write_q;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_RESP:    state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Read data only changes on the edge that completes a read.
    always_comb begin
        if (rd_en_s) begin
            rdata_d = mem_q[mem_idx_s];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            is_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 256'd0;
            rdata_q    <= 256'd0;
            resp_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
            perr_q     <= perr_d;
        end
    end

    // Line storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_wr_s) begin
            mem_q[mem_idx_s] <= mem_wdata_s;
        end
    end

    assign pmem_rdata = rdata_q;
    assign pmem_resp  = resp_q;
    assign proto_err  = perr_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench for pmem_line_responder: a LATENCY=4 and a LATENCY=1 instance
// checked every cycle against a transaction-level model, plus literal pins.
module tb_pmem_line_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b1;
    logic         rd [2];
    logic         wr [2];
    logic [31:0]  addr [2];
    logic [255:0] wd [2];
    logic [255:0] rdata [2];
    logic         resp [2];
    logic         perr [2];

    pmem_line_responder #(.INDEX_BITS(8), .LATENCY(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .pmem_read(rd[0]), .pmem_write(wr[0]),
        .pmem_address(addr[0]), .pmem_wdata(wd[0]), .pmem_rdata(rdata[0]),
        .pmem_resp(resp[0]), .proto_err(perr[0]));

    pmem_line_responder #(.INDEX_BITS(8), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .pmem_read(rd[1]), .pmem_write(wr[1]),
        .pmem_address(addr[1]), .pmem_wdata(wd[1]), .pmem_rdata(rdata[1]),
        .pmem_resp(resp[1]), .proto_err(perr[1]));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input int inst, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s inst%0d cyc%0d got=%h want=%h", nm, inst, cyc, got, exp);
        end
    endtask

    // Transaction-level model: edge numbers decide acceptance and completion.
    bit           m_pend [2];
    int           m_acc [2];
    int           m_ok [2];
    bit           m_op [2];
    int           m_idx [2];
    logic [255:0] m_data [2];
    bit           e_resp [2];
    logic [255:0] e_rdata [2];
    bit           e_known [2];
    bit           e_perr [2];
    logic [255:0] m_mem [int];
    bit           m_req;
    int           m_key;

    function automatic int lat(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            m_req = rd[i] | wr[i];
            if (!rst_n) begin
                m_pend[i] = 1'b0; e_resp[i] = 1'b0; e_rdata[i] = 256'd0;
                e_known[i] = 1'b1; e_perr[i] = 1'b0; m_ok[i] = cyc + 1;
            end else begin
                e_resp[i] = 1'b0;
                if (m_pend[i] && !m_req) begin
                    m_pend[i] = 1'b0; e_perr[i] = 1'b1; m_ok[i] = cyc + 1;
                end else if (m_pend[i]) begin
                    if (rd[i] && wr[i]) e_perr[i] = 1'b1;
                end else if (m_req && cyc >= m_ok[i]) begin
                    m_pend[i] = 1'b1; m_acc[i] = cyc; m_op[i] = wr[i];
                    m_idx[i] = int'(addr[i][12:5]); m_data[i] = wd[i];
                    if (rd[i] && wr[i]) e_perr[i] = 1'b1;
                end
                if (m_pend[i] && cyc == m_acc[i] + lat(i) - 1) begin
                    m_key = i * 1024 + m_idx[i];
                    if (m_op[i]) begin
                        m_mem[m_key] = m_data[i];
                    end else if (m_mem.exists(m_key)) begin
                        e_rdata[i] = m_mem[m_key]; e_known[i] = 1'b1;
                    end else begin
                        e_known[i] = 1'b0;
                    end
                    e_resp[i] = 1'b1; m_pend[i] = 1'b0; m_ok[i] = cyc + 3;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                chk("rst_resp", i, 256'(resp[i]), 256'd0);
                chk("rst_perr", i, 256'(perr[i]), 256'd0);
                chk("rst_rdata", i, rdata[i], 256'd0);
            end else begin
                chk("resp", i, 256'(resp[i]), 256'(e_resp[i]));
                chk("perr", i, 256'(perr[i]), 256'(e_perr[i]));
                if (e_known[i]) chk("rdata", i, rdata[i], e_rdata[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input int i, output int rc, output logic [255:0] rdv);
        rc  = -1;
        rdv = 256'd0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (resp[i]) begin
                rc  = cyc;
                rdv = rdata[i];
                break;
            end
        end
        if (rc < 0) chk("resp_timeout", i, 256'd0, 256'd1);
    endtask

    task automatic do_txn(input int i, input bit r, input bit w, input logic [31:0] a,
                          input logic [255:0] d, output int rc, output logic [255:0] rdv);
        rd[i] = r; wr[i] = w; addr[i] = a; wd[i] = d;
        wait_resp(i, rc, rdv);
        tick();
        rd[i] = 1'b0; wr[i] = 1'b0;
    endtask

    logic [255:0] pat_a5, pat_x, pat_y, pat_w, pat_p, pat_q, pat_r, rdv;
    int rc, c1, c2, c0;

    initial begin
        pat_a5 = {32{8'hA5}};
        pat_x  = {4{64'h0123_4567_89AB_CDEF}};
        pat_y  = {8{32'h5EED_F00D}};
        pat_w  = {16{16'hC0DE}};
        pat_p  = {8{32'h1357_9BDF}};
        pat_q  = {4{64'hAAAA_5555_0F0F_F0F0}};
        pat_r  = {4{64'h1111_2222_3333_4444}};
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'd0; wd[i] = 256'd0;
        end
        #1 rst_n = 1'b0;
        while (cyc < 3) tick();
        chk("reset_rdata", 0, rdata[0], 256'd0);
        chk("reset_resp", 0, 256'(resp[0]), 256'd0);
        rst_n = 1'b1;
        while (cyc < 10) tick();

        // Write issued in cycle 10 must respond in cycle 14, then read back.
        do_txn(0, 1'b0, 1'b1, 32'h0000_0040, pat_a5, rc, rdv);
        chk("write_resp_cycle", 0, 256'(rc), 256'd14);
        do_txn(0, 1'b1, 1'b0, 32'h0000_0040, 256'd0, rc, rdv);
        chk("read_a5", 0, rdv, pat_a5);
        chk("read_perr", 0, 256'(perr[0]), 256'd0);

        // Aliasing on upper address bits and ignored offset bits.
        do_txn(0, 1'b0, 1'b1, 32'h0000_2020, pat_x, rc, rdv);
        do_txn(0, 1'b1, 1'b0, 32'h0000_0020, 256'd0, rc, rdv);
        chk("alias_upper", 0, rdv, pat_x);
        do_txn(0, 1'b1, 1'b0, 32'h0000_003F, 256'd0, rc, rdv);
        chk("alias_offset", 0, rdv, pat_x);

        // Read held across two transactions.
        rd[0] = 1'b1; addr[0] = 32'h0000_0040;
        wait_resp(0, c1, rdv);
        wait_resp(0, c2, rdv);
        chk("b2b_spacing", 0, 256'(c2 - c1), 256'd6);
        chk("b2b_data", 0, rdv, pat_a5);
        tick();
        rd[0] = 1'b0;
        repeat (3) tick();

        // Abort by dropping the read two cycles after raising it.
        rd[0] = 1'b1; addr[0] = 32'h0000_0040;
        tick(); tick();
        rd[0] = 1'b0;
        repeat (8) tick();
        chk("abort_perr", 0, 256'(perr[0]), 256'd1);
        do_txn(0, 1'b0, 1'b1, 32'h0000_0060, pat_y, rc, rdv);
        do_txn(0, 1'b1, 1'b0, 32'h0000_0060, 256'd0, rc, rdv);
        chk("after_abort_read", 0, rdv, pat_y);

        // Simultaneous read+write to line 5 from a clean reset.
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        chk("perr_cleared", 0, 256'(perr[0]), 256'd0);
        do_txn(0, 1'b1, 1'b1, 32'h0000_00A0, pat_w, rc, rdv);
        chk("rw_rdata_unchanged", 0, rdv, 256'd0);
        chk("rw_perr", 0, 256'(perr[0]), 256'd1);
        do_txn(0, 1'b1, 1'b0, 32'h0000_00A0, 256'd0, rc, rdv);
        chk("rw_line5", 0, rdv, pat_w);

        // Single-cycle latency instance.
        do_txn(1, 1'b0, 1'b1, 32'h0000_0040, pat_p, rc, rdv);
        repeat (2) tick();
        c0 = cyc;
        do_txn(1, 1'b1, 1'b0, 32'h0000_0040, 256'd0, rc, rdv);
        chk("lat1_resp_cycle", 1, 256'(rc - c0), 256'd1);
        chk("lat1_data", 1, rdv, pat_p);

        // Reset during the busy phase of a write loses that write.
        do_txn(0, 1'b0, 1'b1, 32'h0000_0080, pat_q, rc, rdv);
        repeat (2) tick();
        wr[0] = 1'b1; addr[0] = 32'h0000_0080; wd[0] = pat_r;
        tick(); tick();
        rst_n = 1'b0; wr[0] = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        do_txn(0, 1'b1, 1'b0, 32'h0000_0080, 256'd0, rc, rdv);
        chk("reset_write_lost", 0, rdv, pat_q);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
